// File: rtl/cmd_frame_accumulator.sv
// cmd_frame_accumulator: collects UART bytes into a delimiter- or length-framed buffer held until ack
module cmd_frame_accumulator #(
    parameter int         MAX_BYTES = 128,
    parameter int         SIZE_W    = 8,
    parameter int         TIMEOUT   = 2000,
    parameter logic [7:0] SOF_BYTE  = 8'hA5,
    parameter logic [7:0] EOF_BYTE  = 8'h0D
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   mode_len,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    input  logic                   frame_ack,
    output logic [MAX_BYTES*8-1:0] frame_data,
    output logic [SIZE_W-1:0]      frame_size,
    output logic                   frame_valid,
    output logic                   busy,
    output logic                   error,
    output logic [1:0]             err_code
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, GET_LEN, COLLECT, HOLD} state_t;
    state_t state_q, state_d;
    logic [MAX_BYTES*8-1:0] data_q, data_d;
    logic [SIZE_W-1:0] size_q, size_d, len_q, len_d;
    logic [TW-1:0] timer_q, timer_d;
    logic mode_q, mode_d, error_q, error_d;
    logic [1:0] err_q, err_d;
    logic sof;
    assign sof = enable && in_valid && in_byte == SOF_BYTE;
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        size_d  = size_q;
        len_d   = len_q;
        timer_d = '0;
        mode_d  = mode_q;
        err_d   = err_q;
        error_d = 1'b0;
        // an ack in HOLD frees the buffer in the same cycle, so a new SOF starts without a gap
        if ((state_q == IDLE || (state_q == HOLD && frame_ack)) && sof) begin
            state_d = mode_len ? GET_LEN : COLLECT;
            data_d  = '0;
            size_d  = '0;
            err_d   = 2'd0;
            mode_d  = mode_len;
        end else if (state_q == HOLD) begin
            if (frame_ack) state_d = IDLE;
        end else if (state_q != IDLE) begin
            if (!enable) begin
                state_d = IDLE;
            end else if (!in_valid) begin
                if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_d   = 2'd1;
                    error_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end else if (state_q == GET_LEN) begin
                if (in_byte == 8'd0 || int'(in_byte) > MAX_BYTES) begin
                    state_d = IDLE;
                    err_d   = 2'd3;
                    error_d = 1'b1;
                end else begin
                    len_d   = SIZE_W'(in_byte);
                    state_d = COLLECT;
                end
            end else if (!mode_q && in_byte == EOF_BYTE) begin
                state_d = HOLD;
            end else if (size_q == SIZE_W'(MAX_BYTES)) begin
                state_d = IDLE;
                err_d   = 2'd2;
                error_d = 1'b1;
            end else begin
                for (int i = 0; i < MAX_BYTES; i++)
                    if (size_q == SIZE_W'(i)) data_d[8*i +: 8] = in_byte;
                size_d = size_q + 1'b1;
                if (mode_q && size_d == len_q) state_d = HOLD;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            size_q  <= '0;
            len_q   <= '0;
            timer_q <= '0;
            mode_q  <= 1'b0;
            err_q   <= 2'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            size_q  <= size_d;
            len_q   <= len_d;
            timer_q <= timer_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            error_q <= error_d;
        end
    end
    assign frame_data  = data_q;
    assign frame_size  = size_q;
    assign frame_valid = state_q == HOLD;
    assign busy        = state_q != IDLE;
    assign error       = error_q;
    assign err_code    = err_q;
endmodule

// File: tb/tb_cmd_frame_accumulator.sv
// tb_cmd_frame_accumulator: directed and random frames checked against a queue-based reference model
module tb_cmd_frame_accumulator;
    localparam int MAXB = 4;
    localparam int TO   = 2000;
    logic clk = 1'b0, reset = 1'b1, enable = 1'b1, mode_len = 1'b0, in_valid = 1'b0, frame_ack = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic [MAXB*8-1:0] frame_data;
    logic [2:0] frame_size;
    logic frame_valid, busy, error;
    logic [1:0] err_code;
    int n_vec = 0, n_err = 0;
    int m_phase = 0, m_len = 0, m_idle = 0, m_err = 0;
    bit m_lenmode = 1'b0, m_pulse = 1'b0;
    byte unsigned m_buf[$];

    cmd_frame_accumulator #(.MAX_BYTES(MAXB), .SIZE_W(3), .TIMEOUT(TO), .SOF_BYTE(8'hA5), .EOF_BYTE(8'h0D)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode_len(mode_len), .in_byte(in_byte),
        .in_valid(in_valid), .frame_ack(frame_ack), .frame_data(frame_data), .frame_size(frame_size),
        .frame_valid(frame_valid), .busy(busy), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // phases: 0 idle, 1 waiting for length, 2 collecting, 3 holding a finished frame
    task automatic m_fail(input int code);
        m_phase = 0;
        m_err   = code;
        m_pulse = 1'b1;
    endtask

    task automatic model_step();
        bit sof;
        m_pulse = 1'b0;
        sof = enable && in_valid && in_byte == 8'hA5;
        if (reset) begin
            m_phase = 0;
            m_err   = 0;
            m_idle  = 0;
            m_buf.delete();
        end else if ((m_phase == 0 || (m_phase == 3 && frame_ack)) && sof) begin
            m_buf.delete();
            m_err     = 0;
            m_idle    = 0;
            m_lenmode = mode_len;
            m_phase   = mode_len ? 1 : 2;
        end else if (m_phase == 3) begin
            if (frame_ack) m_phase = 0;
        end else if (m_phase != 0) begin
            if (!enable) m_phase = 0;
            else if (!in_valid) begin
                m_idle++;
                if (m_idle == TO) m_fail(1);
            end else begin
                m_idle = 0;
                if (m_phase == 1) begin
                    if (in_byte == 0 || int'(in_byte) > MAXB) m_fail(3);
                    else begin
                        m_len   = int'(in_byte);
                        m_phase = 2;
                    end
                end else if (!m_lenmode && in_byte == 8'h0D) m_phase = 3;
                else if (m_buf.size() == MAXB) m_fail(2);
                else begin
                    m_buf.push_back(in_byte);
                    if (m_lenmode && m_buf.size() == m_len) m_phase = 3;
                end
            end
        end
    endtask

    function automatic logic [31:0] m_data();
        logic [31:0] d = '0;
        foreach (m_buf[i]) d[8*i +: 8] = m_buf[i];
        return d;
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("frame_valid", 32'(frame_valid), 32'(m_phase == 3));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("error", 32'(error), 32'(m_pulse));
        chk("err_code", 32'(err_code), 32'(m_err));
        chk("frame_size", 32'(frame_size), 32'(m_buf.size()));
        chk("frame_data", frame_data, m_data());
    endtask

    task automatic put(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        cyc();
        frame_ack = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_outputs", {frame_data, 1'b0, frame_size, frame_valid, busy, error, err_code}, 32'h0);
        // delimiter frame
        put(8'hA5); put(8'h01); put(8'h02); put(8'h03);
        chk("t1_not_yet_valid", 32'(frame_valid), 32'd0);
        put(8'h0D);
        chk("t1_valid", 32'(frame_valid), 32'd1);
        chk("t1_size", 32'(frame_size), 32'd3);
        chk("t1_data", frame_data, 32'h00030201);
        cyc();
        ack();
        chk("t1_acked", 32'(frame_valid), 32'd0);
        // length frame; mode_len only matters on the SOF cycle
        mode_len = 1'b1;
        put(8'hA5);
        mode_len = 1'b0;
        put(8'h04); put(8'h0D); put(8'hA5); put(8'h11); put(8'h22);
        chk("t2_size", 32'(frame_size), 32'd4);
        chk("t2_data", frame_data, 32'h2211A50D);
        ack();
        // timeout boundary
        put(8'hA5); put(8'h01);
        repeat (TO - 1) cyc();
        chk("t3_still_busy", 32'(busy), 32'd1);
        cyc();
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_code", 32'(err_code), 32'd1);
        chk("t3_idle", 32'(busy), 32'd0);
        cyc();
        chk("t3_pulse_end", 32'(error), 32'd0);
        // overflow and bad lengths
        put(8'hA5); put(8'h01); put(8'h02); put(8'h03); put(8'h04); put(8'h05);
        chk("t4_overflow", 32'(err_code), 32'd2);
        mode_len = 1'b1;
        put(8'hA5); put(8'h05);
        chk("t4_len_big", 32'(err_code), 32'd3);
        put(8'hA5); put(8'h00);
        chk("t4_len_zero", 32'(err_code), 32'd3);
        mode_len = 1'b0;
        // max-size delimiter frame and empty frame
        put(8'hA5); put(8'h09); put(8'h08); put(8'h07); put(8'h06); put(8'h0D);
        chk("max_size", 32'(frame_size), 32'd4);
        ack();
        put(8'hA5); put(8'h0D);
        chk("empty_valid", 32'(frame_valid), 32'd1);
        ack();
        // held frame ignores bytes, then ack with SOF starts the next frame
        put(8'hA5); put(8'h07); put(8'h08); put(8'h0D);
        for (int k = 0; k < 30; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_byte  = 8'($urandom_range(0, 255));
            cyc();
        end
        in_valid = 1'b0;
        chk("t5_held", frame_data, 32'h00000807);
        frame_ack = 1'b1;
        put(8'hA5);
        frame_ack = 1'b0;
        put(8'h33); put(8'h0D);
        chk("t5_next", frame_data, 32'h00000033);
        ack();
        // enable low aborts silently and blocks SOF
        put(8'hA5); put(8'h11);
        enable = 1'b0;
        cyc();
        chk("abort_idle", 32'(busy), 32'd0);
        put(8'hA5);
        chk("sof_ignored", 32'(busy), 32'd0);
        enable = 1'b1;
        ack();
        // reset mid-collect
        put(8'hA5); put(8'h11); put(8'h22);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_cleared", {frame_data, 1'b0, frame_size, frame_valid, busy, error, err_code}, 32'h0);
        put(8'hA5); put(8'h44); put(8'h0D);
        chk("t6_new", frame_data, 32'h00000044);
        ack();
        for (int k = 0; k < 3000; k++) begin
            reset     = $urandom_range(0, 199) == 0;
            enable    = $urandom_range(0, 19) != 0;
            mode_len  = 1'($urandom_range(0, 1));
            frame_ack = $urandom_range(0, 4) == 0;
            in_valid  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0, 1:    in_byte = 8'hA5;
                2:       in_byte = 8'h0D;
                3:       in_byte = 8'($urandom_range(0, 6));
                default: in_byte = 8'($urandom_range(0, 255));
            endcase
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
